// File: rtl/tx_symbol_scheduler.sv
// Arbitrates requesters A and B onto the serializer parallel input, one symbol per BITS_PER_SYM clocks.
// Optional periodic SKP ordered-set insertion is compiled in with `define SKP_INSERT_EN.
module tx_symbol_scheduler #(
  parameter int SYM_W        = 10,
  parameter int BITS_PER_SYM = 10,
  parameter int SKP_INTERVAL = 64
) (
  input  logic             CLOCK,
  input  logic             RESET_L,
  input  logic             REQ_A,
  input  logic [SYM_W-1:0] DATA_A,
  input  logic             LAST_A,
  output logic             GNT_A,
  input  logic             REQ_B,
  input  logic [SYM_W-1:0] DATA_B,
  input  logic             LAST_B,
  output logic             GNT_B,
  output logic [SYM_W-1:0] SYM_OUT,
  output logic             SYM_LOAD,
  output logic             LINK_IDLE
);

  localparam int               CNT_W    = (BITS_PER_SYM > 1) ? $clog2(BITS_PER_SYM) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_SYM - 1);
  localparam logic [SYM_W-1:0] SYM_COM  = SYM_W'(10'b0011111010);

  if (BITS_PER_SYM < 2 || SKP_INTERVAL < 1 || SYM_W < 1) begin : g_param_check
    $error("tx_symbol_scheduler: invalid parameter values");
  end

`ifdef SKP_INSERT_EN
  localparam logic [SYM_W-1:0] SYM_SKP   = SYM_W'(10'b0011110100);
  localparam int               SKP_CNT_W = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
  localparam logic [SKP_CNT_W-1:0] SKP_LAST = SKP_CNT_W'(SKP_INTERVAL - 1);

  typedef enum logic [1:0] {ST_ARB, ST_OWN_A, ST_OWN_B, ST_SKP} state_t;
`else
  typedef enum logic [1:0] {ST_ARB, ST_OWN_A, ST_OWN_B} state_t;
`endif

  logic [CNT_W-1:0] r_bit_cnt;
  state_t           r_state;
  logic             r_rr_b;
  logic [SYM_W-1:0] r_sym_out;
  logic             r_sym_load;
  logic             r_link_idle;

  logic             w_boundary;
  logic             w_gnt_a;
  logic             w_gnt_b;
  state_t           w_state_nx;
  logic [SYM_W-1:0] w_sym_nx;
  logic             w_idle_nx;
  logic             w_rr_nx;

`ifdef SKP_INSERT_EN
  logic [SKP_CNT_W-1:0] r_skp_cnt;
  logic                 r_skp_pending;
  logic [1:0]           r_skp_idx;
  logic                 r_sym_os;
  logic                 w_os_nx;
  logic                 w_skp_done;
  logic [1:0]           w_skp_idx_nx;
`endif

  assign w_boundary = (r_bit_cnt == LAST_BIT);

  always_comb begin
    w_gnt_a    = 1'b0;
    w_gnt_b    = 1'b0;
    w_state_nx = r_state;
    w_sym_nx   = SYM_COM;
    w_idle_nx  = 1'b0;
    w_rr_nx    = r_rr_b;
`ifdef SKP_INSERT_EN
    w_os_nx      = 1'b0;
    w_skp_done   = 1'b0;
    w_skp_idx_nx = r_skp_idx;
`endif
    if (w_boundary) begin
      case (r_state)
        ST_ARB: begin
`ifdef SKP_INSERT_EN
          // COM leads the ordered set; the three SKPs follow from ST_SKP
          if (r_skp_pending) begin
            w_os_nx      = 1'b1;
            w_state_nx   = ST_SKP;
            w_skp_idx_nx = 2'd0;
          end else
`endif
          if (REQ_A && (!REQ_B || !r_rr_b)) begin
            w_gnt_a  = 1'b1;
            w_sym_nx = DATA_A;
            if (LAST_A) begin
              w_rr_nx = 1'b1;
            end else begin
              w_state_nx = ST_OWN_A;
            end
          end else if (REQ_B) begin
            w_gnt_b  = 1'b1;
            w_sym_nx = DATA_B;
            if (LAST_B) begin
              w_rr_nx = 1'b0;
            end else begin
              w_state_nx = ST_OWN_B;
            end
          end else begin
            w_idle_nx = 1'b1;
          end
        end
        ST_OWN_A: begin
          if (REQ_A) begin
            w_gnt_a  = 1'b1;
            w_sym_nx = DATA_A;
            if (LAST_A) begin
              w_state_nx = ST_ARB;
              w_rr_nx    = 1'b1;
            end
          end
        end
        ST_OWN_B: begin
          if (REQ_B) begin
            w_gnt_b  = 1'b1;
            w_sym_nx = DATA_B;
            if (LAST_B) begin
              w_state_nx = ST_ARB;
              w_rr_nx    = 1'b0;
            end
          end
        end
`ifdef SKP_INSERT_EN
        ST_SKP: begin
          w_sym_nx = SYM_SKP;
          w_os_nx  = 1'b1;
          if (r_skp_idx == 2'd2) begin
            w_state_nx = ST_ARB;
            w_skp_done = 1'b1;
          end else begin
            w_skp_idx_nx = r_skp_idx + 2'd1;
          end
        end
`endif
        default: begin
          w_state_nx = ST_ARB;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_bit_cnt   <= '0;
      r_state     <= ST_ARB;
      r_rr_b      <= 1'b0;
      r_sym_out   <= SYM_COM;
      r_sym_load  <= 1'b0;
      r_link_idle <= 1'b1;
`ifdef SKP_INSERT_EN
      r_sym_os    <= 1'b0;
      r_skp_idx   <= 2'd0;
`endif
    end else begin
      r_bit_cnt  <= w_boundary ? '0 : r_bit_cnt + 1'b1;
      r_sym_load <= w_boundary;
      if (w_boundary) begin
        r_state     <= w_state_nx;
        r_sym_out   <= w_sym_nx;
        r_link_idle <= w_idle_nx;
        r_rr_b      <= w_rr_nx;
`ifdef SKP_INSERT_EN
        r_sym_os    <= w_os_nx;
        r_skp_idx   <= w_skp_idx_nx;
`endif
      end
    end
  end

`ifdef SKP_INSERT_EN
  // Loads belonging to an ordered set, or made while one is owed, do not advance the interval
  always_ff @(posedge CLOCK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_skp_cnt     <= '0;
      r_skp_pending <= 1'b0;
    end else begin
      if (w_skp_done) begin
        r_skp_pending <= 1'b0;
      end else if (r_sym_load && !r_sym_os && !r_skp_pending) begin
        if (r_skp_cnt == SKP_LAST) begin
          r_skp_cnt     <= '0;
          r_skp_pending <= 1'b1;
        end else begin
          r_skp_cnt <= r_skp_cnt + 1'b1;
        end
      end
    end
  end
`endif

  assign GNT_A     = w_gnt_a;
  assign GNT_B     = w_gnt_b;
  assign SYM_OUT   = r_sym_out;
  assign SYM_LOAD  = r_sym_load;
  assign LINK_IDLE = r_link_idle;

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Directed bench for tx_symbol_scheduler: queue-driven requesters, a per-boundary arbitration
// model checked every cycle, and literal pins on the grant and load logs of each scenario.
module tb_tx_symbol_scheduler;

  localparam int W    = 10;
  localparam int BPS  = 10;
  localparam int SKPI = 4;
`ifdef SKP_INSERT_EN
  localparam bit SKP_EN = 1'b1;
`else
  localparam bit SKP_EN = 1'b0;
`endif
  localparam logic [9:0] COM = 10'b0011111010;
  localparam logic [9:0] SKP = 10'b0011110100;

  logic         CLOCK = 1'b0;
  logic         RESET_L = 1'b0;
  logic         REQ_A = 1'b0, LAST_A = 1'b0, REQ_B = 1'b0, LAST_B = 1'b0;
  logic [W-1:0] DATA_A = '0, DATA_B = '0;
  logic         GNT_A, GNT_B, SYM_LOAD, LINK_IDLE;
  logic [W-1:0] SYM_OUT;

  tx_symbol_scheduler #(.SYM_W(W), .BITS_PER_SYM(BPS), .SKP_INTERVAL(SKPI)) dut (
    .CLOCK(CLOCK), .RESET_L(RESET_L),
    .REQ_A(REQ_A), .DATA_A(DATA_A), .LAST_A(LAST_A), .GNT_A(GNT_A),
    .REQ_B(REQ_B), .DATA_B(DATA_B), .LAST_B(LAST_B), .GNT_B(GNT_B),
    .SYM_OUT(SYM_OUT), .SYM_LOAD(SYM_LOAD), .LINK_IDLE(LINK_IDLE)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    int         gap;
    logic [9:0] d;
    logic       last;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];

  int checks = 0;
  int errors = 0;

  // model of the registered outputs and the arbitration context
  int         m_cnt, m_owner, m_skp_left, m_lcnt, cyc, bnd;
  logic       m_load, m_idle, m_os, m_fav_b, m_pend;
  logic [9:0] m_sym;

  logic [10:0] gnt_log[$];
  int          gnt_bnd[$];
  logic [10:0] sym_log[$];
  int          load_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic missing(input string name);
    checks++;
    errors++;
    $display("FAIL %s: log entry absent, expected one at t=%0t", name, $time);
  endtask

  task automatic pin_gnt(input string name, input int idx, input logic [10:0] exp);
    if (idx < gnt_log.size()) check(name, 32'(gnt_log[idx]), 32'(exp));
    else missing(name);
  endtask

  task automatic pin_sym(input string name, input int idx, input logic [10:0] exp);
    if (idx < sym_log.size()) check(name, 32'(sym_log[idx]), 32'(exp));
    else missing(name);
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    gnt_bnd.delete();
    sym_log.delete();
    load_cyc.delete();
  endtask

  task automatic drive();
    REQ_A  = (qa.size() > 0) && (qa[0].gap == 0);
    DATA_A = (qa.size() > 0) ? qa[0].d : 10'h000;
    LAST_A = (qa.size() > 0) ? qa[0].last : 1'b0;
    REQ_B  = (qb.size() > 0) && (qb[0].gap == 0);
    DATA_B = (qb.size() > 0) ? qb[0].d : 10'h000;
    LAST_B = (qb.size() > 0) ? qb[0].last : 1'b0;
  endtask

  task automatic model_reset();
    m_cnt = 0; m_owner = 0; m_skp_left = 0; m_lcnt = 0; cyc = 0; bnd = 0;
    m_load = 1'b0; m_idle = 1'b1; m_os = 1'b0; m_fav_b = 1'b0; m_pend = 1'b0;
    m_sym = COM;
  endtask

  task automatic push(input bit to_a, input int gap, input logic [9:0] d, input logic last);
    ent_t e;
    e.gap = gap; e.d = d; e.last = last;
    if (to_a) qa.push_back(e);
    else qb.push_back(e);
  endtask

  // Hold reset two cycles, pin the reset outputs, release on a falling edge.
  task automatic do_reset();
    RESET_L = 1'b0;
    qa.delete();
    qb.delete();
    drive();
    repeat (2) @(negedge CLOCK);
    check("rst_sym_out", 32'(SYM_OUT), 32'(COM));
    check("rst_sym_load", 32'(SYM_LOAD), 32'd0);
    check("rst_link_idle", 32'(LINK_IDLE), 32'd1);
    check("rst_gnt", 32'({GNT_A, GNT_B}), 32'd0);
    RESET_L = 1'b1;
    model_reset();
    #1;
  endtask

  // One clock: compare against the model, then advance model and requesters.
  task automatic step();
    logic       boundary, ra, rb, pick_a, ega, egb, nx_idle, nx_os, clr_pend, nx_fav;
    logic [9:0] nx_sym;
    int         nx_owner, nx_left;
    ent_t       e;
    boundary = (m_cnt == BPS - 1);
    ra = REQ_A; rb = REQ_B;
    ega = 1'b0; egb = 1'b0; nx_sym = COM; nx_idle = 1'b0; nx_os = 1'b0;
    nx_owner = m_owner; nx_fav = m_fav_b; nx_left = m_skp_left; clr_pend = 1'b0;
    if (boundary) begin
      if (m_skp_left > 0) begin
        nx_sym = SKP; nx_os = 1'b1; nx_left = m_skp_left - 1;
        if (nx_left == 0) clr_pend = 1'b1;
      end else if (m_owner == 0) begin
        if (SKP_EN && m_pend) begin
          nx_os = 1'b1; nx_left = 3;
        end else if (ra || rb) begin
          pick_a = ra && (!rb || !m_fav_b);
          if (pick_a) begin
            ega = 1'b1; nx_sym = DATA_A;
            if (LAST_A) nx_fav = 1'b1; else nx_owner = 1;
          end else begin
            egb = 1'b1; nx_sym = DATA_B;
            if (LAST_B) nx_fav = 1'b0; else nx_owner = 2;
          end
        end else begin
          nx_idle = 1'b1;
        end
      end else if (m_owner == 1) begin
        if (ra) begin
          ega = 1'b1; nx_sym = DATA_A;
          if (LAST_A) begin nx_owner = 0; nx_fav = 1'b1; end
        end
      end else begin
        if (rb) begin
          egb = 1'b1; nx_sym = DATA_B;
          if (LAST_B) begin nx_owner = 0; nx_fav = 1'b0; end
        end
      end
    end
    check("gnt_a", 32'(GNT_A), 32'(ega));
    check("gnt_b", 32'(GNT_B), 32'(egb));
    check("sym_out", 32'(SYM_OUT), 32'(m_sym));
    check("sym_load", 32'(SYM_LOAD), 32'(m_load));
    check("link_idle", 32'(LINK_IDLE), 32'(m_idle));
    if (SYM_LOAD) begin
      sym_log.push_back({LINK_IDLE, SYM_OUT});
      load_cyc.push_back(cyc);
      $display("load cyc=%0d sym=%03h idle=%0b", cyc, SYM_OUT, LINK_IDLE);
    end
    if (GNT_A || GNT_B) begin
      gnt_log.push_back({GNT_A, GNT_A ? DATA_A : DATA_B});
      gnt_bnd.push_back(bnd);
    end
    if (m_load && !m_os && !m_pend) begin
      m_lcnt++;
      if (m_lcnt == SKPI) begin
        m_lcnt = 0;
        if (SKP_EN) m_pend = 1'b1;
      end
    end
    @(posedge CLOCK);
    m_cnt  = boundary ? 0 : m_cnt + 1;
    m_load = boundary;
    cyc++;
    if (boundary) begin
      m_sym = nx_sym; m_idle = nx_idle; m_os = nx_os; m_owner = nx_owner;
      m_fav_b = nx_fav; m_skp_left = nx_left;
      if (clr_pend) m_pend = 1'b0;
      bnd++;
      if (ega) void'(qa.pop_front());
      else if (qa.size() > 0 && qa[0].gap > 0) begin e = qa[0]; e.gap--; qa[0] = e; end
      if (egb) void'(qb.pop_front());
      else if (qb.size() > 0 && qb[0].gap > 0) begin e = qb[0]; e.gap--; qb[0] = e; end
    end
    #1;
    drive();
    @(negedge CLOCK);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int nskp;

    // idle link: COM loads every BITS_PER_SYM clocks
    do_reset();
    clear_logs();
    run(41);
    for (int i = 0; i < 4; i++) begin
      if (i < load_cyc.size()) check("t1_load_cycle", 32'(load_cyc[i]), 32'(10 * (i + 1)));
      else missing("t1_load_cycle");
      pin_sym("t1_idle_com", i, {1'b1, COM});
    end
    check("t1_no_grant", 32'(gnt_log.size()), 32'd0);

    // A burst of three, B waiting behind it
    clear_logs();
    push(1'b1, 0, 10'h155, 1'b0);
    push(1'b1, 0, 10'h2AA, 1'b0);
    push(1'b1, 0, 10'h0F0, 1'b1);
    push(1'b0, 0, 10'h3C3, 1'b1);
    drive();
    run(90);
    pin_gnt("t2_g0", 0, {1'b1, 10'h155});
    pin_gnt("t2_g1", 1, {1'b1, 10'h2AA});
    pin_gnt("t2_g2", 2, {1'b1, 10'h0F0});
    pin_gnt("t2_g3", 3, {1'b0, 10'h3C3});
    if (gnt_bnd.size() >= 4) check("t2_consecutive", 32'(gnt_bnd[3] - gnt_bnd[0]), 32'd3);
    else missing("t2_consecutive");

    // single-symbol requests from both sides alternate, A first
    do_reset();
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      push(1'b1, 0, 10'h0A0 + 10'(k), 1'b1);
      push(1'b0, 0, 10'h0B0 + 10'(k), 1'b1);
    end
    drive();
    run(175);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) pin_gnt("t3_alt", i, {1'b1, 10'h0A0 + 10'(i / 2)});
      else pin_gnt("t3_alt", i, {1'b0, 10'h0B0 + 10'(i / 2)});
    end

    // underrun inside A's burst: two filler COMs, B locked out
    do_reset();
    clear_logs();
    push(1'b1, 0, 10'h101, 1'b0);
    push(1'b1, 2, 10'h102, 1'b0);
    push(1'b1, 0, 10'h103, 1'b1);
    push(1'b0, 0, 10'h3C3, 1'b1);
    drive();
    run(110);
    pin_gnt("t4_g0", 0, {1'b1, 10'h101});
    pin_gnt("t4_g1", 1, {1'b1, 10'h102});
    pin_gnt("t4_g2", 2, {1'b1, 10'h103});
    pin_gnt("t4_g3", 3, {1'b0, 10'h3C3});
    pin_sym("t4_first", 0, {1'b0, 10'h101});
    pin_sym("t4_under0", 1, {1'b0, COM});
    pin_sym("t4_under1", 2, {1'b0, COM});
    pin_sym("t4_resume", 3, {1'b0, 10'h102});

    // SKP ordered set after SKP_INTERVAL loads, or never when compiled out
    do_reset();
    clear_logs();
    for (int k = 0; k < 6; k++) push(1'b1, 0, 10'h040 + 10'(k), 1'b1);
    drive();
    run(120);
    nskp = 0;
    foreach (sym_log[i]) if (sym_log[i][9:0] == SKP) nskp++;
    if (SKP_EN) begin
      for (int i = 0; i < 4; i++) pin_sym("t5_pre", i, {1'b0, 10'h040 + 10'(i)});
      pin_sym("t5_os_com", 4, {1'b0, COM});
      for (int i = 5; i < 8; i++) pin_sym("t5_os_skp", i, {1'b0, SKP});
      pin_sym("t5_after", 8, {1'b0, 10'h044});
      check("t5_skp_count", 32'(nskp), 32'd3);
    end else begin
      for (int i = 0; i < 6; i++) pin_sym("t5_plain", i, {1'b0, 10'h040 + 10'(i)});
      check("t5_skp_count", 32'(nskp), 32'd0);
    end

    // reset asserted mid-burst at bit counter 5
    do_reset();
    clear_logs();
    push(1'b1, 0, 10'h001, 1'b0);
    push(1'b1, 0, 10'h002, 1'b0);
    push(1'b1, 0, 10'h003, 1'b0);
    push(1'b1, 0, 10'h004, 1'b1);
    drive();
    run(25);
    check("t6_pre_sym", 32'(SYM_OUT), 32'h002);
    RESET_L = 1'b0;
    #1;
    check("t6_async_sym", 32'(SYM_OUT), 32'(COM));
    check("t6_async_load", 32'(SYM_LOAD), 32'd0);
    check("t6_async_idle", 32'(LINK_IDLE), 32'd1);
    check("t6_async_gnt", 32'({GNT_A, GNT_B}), 32'd0);
    do_reset();
    clear_logs();
    run(12);
    if (load_cyc.size() > 0) check("t6_first_load", 32'(load_cyc[0]), 32'd10);
    else missing("t6_first_load");
    pin_sym("t6_first_sym", 0, {1'b1, COM});
    check("t6_no_grant", 32'(gnt_log.size()), 32'd0);
    push(1'b0, 0, 10'h2C2, 1'b1);
    drive();
    run(12);
    pin_gnt("t6_arb_b", 0, {1'b0, 10'h2C2});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
